// File: rtl/memory_game_ctrl_if.sv
// memory_game_ctrl_if: player inputs and display/status outputs of the memory game sequencer
interface memory_game_ctrl_if #(
  parameter int NBITS_PAT = 6
);
  logic                 start;
  logic                 commit;
  logic [NBITS_PAT-1:0] guess;
  logic [7:0]           led;
  logic [7:0]           seg;
  logic [7:0]           score;
  logic [1:0]           lives;
  logic [2:0]           state;
  modport master (output start, commit, guess, input led, seg, score, lives, state);
  modport slave  (input start, commit, guess, output led, seg, score, lives, state);
endinterface

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: shows an LFSR pattern, scores the committed guess, tracks score and lives
module memory_game_ctrl #(
  parameter int                   NBITS_PAT     = 6,
  parameter int                   SHOW_CYCLES   = 8,
  parameter int                   RESULT_CYCLES = 4,
  parameter int                   MAX_LIVES     = 3,
  parameter logic [NBITS_PAT-1:0] LFSR_SEED     = 'h2D
) (
  input  logic                clk_2,
  input  logic                reset,
  memory_game_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, SHOW = 3'd1, ENTER = 3'd2, RESULT = 3'd3, OVER = 3'd4} state_t;
  localparam logic [7:0] SHOW_LAST = 8'(SHOW_CYCLES - 1);
  localparam logic [7:0] RES_LAST  = 8'(RESULT_CYCLES - 1);
  localparam logic [1:0] LIVES0    = 2'(MAX_LIVES);
  state_t               st, st_n;
  logic [7:0]           score, score_n, cnt, cnt_n;
  logic [1:0]           lives, lives_n;
  logic [NBITS_PAT-1:0] lfsr, lfsr_n, pattern, pattern_n, guess_l, guess_l_n, lfsr_adv;
  logic                 match, match_n, start_q, commit_q, start_e, commit_e, hit;
  assign start_e  = bus.start & ~start_q;
  assign commit_e = bus.commit & ~commit_q;
  assign lfsr_adv = {lfsr[NBITS_PAT-2:0], lfsr[NBITS_PAT-1] ^ lfsr[NBITS_PAT-2]};
  assign hit      = bus.guess == pattern;
  // round sequencing: every new SHOW draws a fresh pattern, the commit edge scores the guess
  always_comb begin
    st_n      = st;
    score_n   = score;
    lives_n   = lives;
    lfsr_n    = lfsr;
    pattern_n = pattern;
    guess_l_n = guess_l;
    match_n   = match;
    cnt_n     = cnt;
    case (st)
      IDLE, OVER: if (start_e) begin
        st_n      = SHOW;
        score_n   = 8'd0;
        lives_n   = LIVES0;
        lfsr_n    = lfsr_adv;
        pattern_n = lfsr_adv;
        cnt_n     = 8'd0;
      end
      SHOW: begin
        cnt_n = cnt + 8'd1;
        st_n  = cnt == SHOW_LAST ? ENTER : SHOW;
      end
      ENTER: if (commit_e) begin
        st_n      = RESULT;
        guess_l_n = bus.guess;
        match_n   = hit;
        cnt_n     = 8'd0;
        score_n   = hit && score != 8'hFF ? score + 8'd1 : score;
        lives_n   = hit ? lives : lives - 2'd1;
      end
      RESULT: begin
        cnt_n = cnt + 8'd1;
        if (cnt == RES_LAST) begin
          st_n = lives == 2'd0 ? OVER : SHOW;
          if (lives != 2'd0) begin
            lfsr_n    = lfsr_adv;
            pattern_n = lfsr_adv;
            cnt_n     = 8'd0;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end
  // state and datapath registers, input edge history
  always_ff @(posedge clk_2) begin
    if (reset) begin
      st       <= IDLE;
      score    <= 8'd0;
      lives    <= LIVES0;
      lfsr     <= LFSR_SEED;
      pattern  <= '0;
      guess_l  <= '0;
      match    <= 1'b0;
      cnt      <= 8'd0;
      start_q  <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      st       <= st_n;
      score    <= score_n;
      lives    <= lives_n;
      lfsr     <= lfsr_n;
      pattern  <= pattern_n;
      guess_l  <= guess_l_n;
      match    <= match_n;
      cnt      <= cnt_n;
      start_q  <= bus.start;
      commit_q <= bus.commit;
    end
  end
  // Moore display decode: pattern in SHOW, wrong bits in RESULT, final score in OVER
  always_comb begin
    bus.led = st == SHOW ? 8'(pattern) : st == RESULT ? 8'(guess_l ^ pattern) : st == OVER ? score : 8'h00;
    bus.seg = st == RESULT ? (match ? 8'hFF : 8'h80) : st == OVER ? 8'h80 : 8'h00;
  end
  assign bus.score = score;
  assign bus.lives = lives;
  assign bus.state = st;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb_memory_game_ctrl: randomized games checked by a round-level model through a transition scoreboard
module tb_memory_game_ctrl;
  localparam int N = 6, SC = 8, RC = 4, ML = 3;
  localparam logic [5:0] SEED = 6'h2D;
  typedef struct {
    int         st;
    logic [7:0] led;
    logic [7:0] seg;
    logic [7:0] score;
    logic [1:0] lives;
    int         dur;
  } rec_t;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  memory_game_ctrl_if #(.NBITS_PAT(N)) bus ();
  memory_game_ctrl #(.NBITS_PAT(N), .SHOW_CYCLES(SC), .RESULT_CYCLES(RC), .MAX_LIVES(ML), .LFSR_SEED(SEED))
    dut (.clk_2(clk_2), .reset(reset), .bus(bus));
  always #5 clk_2 = ~clk_2;
  rec_t q[$];
  rec_t cur;
  int n_cmp = 0, n_bad = 0, prev_st = 0, dur_cnt = 0;
  bit mon_en = 1'b0;
  logic [5:0] m_lfsr, m_pat;
  int m_score, m_lives;
  function automatic logic [5:0] lfsr_next(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction
  task automatic expect_rec(input int st, input logic [7:0] led, input logic [7:0] seg, input int dur);
    rec_t r;
    r.st = st; r.led = led; r.seg = seg; r.score = 8'(m_score); r.lives = 2'(m_lives); r.dur = dur;
    q.push_back(r);
  endtask
  // monitor: every state change pops one expected record; outputs are held to it every cycle
  always @(negedge clk_2) begin
    if (mon_en) begin
      if (int'(bus.state) != prev_st) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_transition: state %0d -> %0d, no transition required", prev_st, bus.state);
          cur.st = int'(bus.state); cur.led = bus.led; cur.seg = bus.seg;
          cur.score = bus.score; cur.lives = bus.lives; cur.dur = -1;
        end else begin
          cur = q.pop_front();
          if (int'(bus.state) != cur.st) begin
            n_bad++;
            $display("FAIL transition: state %0d -> %0d, required %0d", prev_st, bus.state, cur.st);
          end
          if (cur.dur >= 0) begin
            n_cmp++;
            if (dur_cnt != cur.dur) begin
              n_bad++;
              $display("FAIL duration: state %0d lasted %0d cycles, required %0d", prev_st, dur_cnt, cur.dur);
            end
          end
        end
        prev_st = int'(bus.state);
        dur_cnt = 1;
      end else dur_cnt++;
      n_cmp++;
      if (bus.led !== cur.led || bus.seg !== cur.seg || bus.score !== cur.score || bus.lives !== cur.lives) begin
        n_bad++;
        $display("FAIL outputs: state %0d led=%h seg=%h score=%0d lives=%0d, required led=%h seg=%h score=%0d lives=%0d",
                 bus.state, bus.led, bus.seg, bus.score, bus.lives, cur.led, cur.seg, cur.score, cur.lives);
      end
    end
  end
  task automatic wait_state(input int s);
    int k = 0;
    while (int'(bus.state) != s && k < 300) begin
      @(negedge clk_2);
      k++;
    end
    if (int'(bus.state) != s) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_state: state %0d after %0d cycles, required %0d", bus.state, k, s);
    end
  endtask
  task automatic start_game();
    int k = 0;
    while (bus.state != 3'd0 && bus.state != 3'd4 && k < 300) begin
      @(negedge clk_2);
      k++;
    end
    m_lfsr = lfsr_next(m_lfsr); m_pat = m_lfsr; m_score = 0; m_lives = ML;
    bus.start = 1'b1;
    expect_rec(1, {2'b00, m_pat}, 8'h00, -1);
    expect_rec(2, 8'h00, 8'h00, SC);
    @(negedge clk_2);
    bus.start = 1'b0;
  endtask
  // mode 0: random guess, 1: correct guess, 2: wrong guess
  task automatic play_round(input int mode);
    logic [5:0] g;
    logic hit;
    wait_state(2);
    g = mode == 1 ? m_pat : mode == 2 ? m_pat ^ 6'($urandom_range(1, 63)) :
        $urandom_range(0, 1) == 1 ? m_pat : 6'($urandom);
    bus.guess = 6'($urandom);
    bus.commit = 1'b0;
    @(negedge clk_2);
    bus.guess = g;
    bus.commit = 1'b1;
    hit = g == m_pat;
    if (hit) m_score = m_score < 255 ? m_score + 1 : 255;
    else m_lives--;
    expect_rec(3, {2'b00, g ^ m_pat}, hit ? 8'hFF : 8'h80, -1);
    if (m_lives == 0) expect_rec(4, 8'(m_score), 8'h80, RC);
    else begin
      m_lfsr = lfsr_next(m_lfsr); m_pat = m_lfsr;
      expect_rec(1, {2'b00, m_pat}, 8'h00, RC);
      expect_rec(2, 8'h00, 8'h00, SC);
    end
    @(negedge clk_2);
    bus.commit = 1'b0;
    bus.guess = 6'($urandom);
  endtask
  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  initial begin
    int k;
    bus.start = 1'b0; bus.commit = 1'b0; bus.guess = '0;
    repeat (2) @(negedge clk_2);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_led", int'(bus.led), 0);
    chk("reset_seg", int'(bus.seg), 0);
    chk("reset_score", int'(bus.score), 0);
    chk("reset_lives", int'(bus.lives), ML);
    reset = 1'b0;
    m_lfsr = SEED; m_score = 0; m_lives = ML;
    cur.st = 0; cur.led = 0; cur.seg = 0; cur.score = 0; cur.lives = 2'(ML); cur.dur = -1;
    prev_st = 0; dur_cnt = 0; mon_en = 1'b1;
    start_game();
    play_round(1);
    play_round(2);
    wait_state(2);
    m_lfsr = SEED; m_score = 0; m_lives = ML;
    expect_rec(0, 8'h00, 8'h00, -1);
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    chk("midgame_reset_score", int'(bus.score), 0);
    chk("midgame_reset_lives", int'(bus.lives), ML);
    start_game();
    @(negedge clk_2);
    bus.commit = 1'b1;
    @(negedge clk_2);
    bus.commit = 1'b0;
    @(negedge clk_2);
    bus.commit = 1'b1;
    wait_state(2);
    repeat (4) @(negedge clk_2);
    chk("held_commit_stays_enter", int'(bus.state), 2);
    play_round(0);
    k = 0;
    while (m_lives > 0 && k < 60) begin
      play_round(0);
      k++;
    end
    start_game();
    for (int i = 0; i < 258; i++) play_round(1);
    for (int i = 0; i < 3; i++) play_round(2);
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk_2);
      k++;
    end
    chk("scoreboard_drained", q.size(), 0);
    repeat (3) @(negedge clk_2);
    chk("final_state_over", int'(bus.state), 4);
    chk("final_score_saturated", int'(bus.score), 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
Round sequencer for the binary-LED memory game. It generates a pseudo-random pattern and shows it on the LEDs for a fixed time, then blanks it. It waits for the player to commit a guess on the switches, scores the guess on the 7-segment display, and tracks score and lives until the game is over. The block sits between the board switch inputs (SWI) and the LED/SEG outputs in top.

Parameters:
NBITS_PAT, 6, width of the pattern and the guess; the pattern is displayed on led[NBITS_PAT-1:0]
SHOW_CYCLES, 8, number of clk_2 cycles the pattern stays visible (1..255)
RESULT_CYCLES, 4, number of clk_2 cycles the result stays on seg/led (1..255)
MAX_LIVES, 3, lives at game start (1..3)
LFSR_SEED, 6'h2D, LFSR reset value; must be nonzero

Ports:
clk_2  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high; overrides all other inputs
start  input  1  level input; its rising edge starts a game
commit  input  1  level input; its rising edge submits the guess
guess  input  NBITS_PAT  player guess (SWI[6:1])
led  output  8  LED drive
seg  output  8  7-segment drive; bit 7 is the decimal point
score  output  8  correct rounds in the current game; saturates at 255
lives  output  2  lives remaining
state  output  3  encoding: IDLE=0, SHOW=1, ENTER=2, RESULT=3, OVER=4

Behaviour:
- Edge detect:
  - start_q and commit_q register the inputs every cycle.
  - An edge is input=1 while its _q=0.
  - start_q and commit_q reset to 0, so an input that is high on the first cycle after reset counts as an edge.
- Reset values:
  - state=IDLE, score=0, lives=MAX_LIVES.
  - lfsr=LFSR_SEED, pattern=0, guess_l=0, match=0, cnt=0.
  - led=0, seg=0.
- LFSR: next = {lfsr[4:0], lfsr[5]^lfsr[4]}. It advances only on the cycle that enters SHOW. pattern takes the new value on that same cycle.
- Outputs are decoded from registered state (Moore).
  - IDLE and ENTER: led=0, seg=0.
  - SHOW: led = zero-extended pattern, seg=0.
  - RESULT: seg = match ? 8'hFF : 8'h80; led = zero-extended (guess_l ^ pattern), which shows the wrong bits.
  - OVER: seg=8'h80, led=score.
- IDLE: a start edge moves to SHOW on the next clock. That edge also clears score, sets lives=MAX_LIVES, advances the LFSR and sets cnt=0.
- SHOW:
  - cnt increments each cycle.
  - When cnt==SHOW_CYCLES-1, go to ENTER. SHOW therefore lasts exactly SHOW_CYCLES cycles.
- ENTER:
  - Waits indefinitely for a commit edge.
  - On the edge: guess_l<=guess, match<=(guess==pattern), cnt<=0, go to RESULT.
  - On the same edge, if match: score<=score+1, saturating at 255.
  - On the same edge, if no match: lives<=lives-1.
  - guess changes that occur before the edge have no effect.
- RESULT: lasts RESULT_CYCLES cycles. It then goes to OVER if lives==0. Otherwise it goes to SHOW with a new pattern (LFSR advance, cnt=0).
- OVER:
  - Holds until a start edge.
  - On the start edge, behaves exactly as the IDLE start path.
- Ignored events:
  - start edges in SHOW, ENTER or RESULT.
  - commit edges outside ENTER. commit_q still tracks the input, so a commit held high from SHOW into ENTER does not register until it is released and raised again.
- Reset mid-game: the next clock gives full reset values. The first pattern after reset is always next(LFSR_SEED).
- Invalid state encodings go to IDLE.

Test Plan:
1. Reset high for 2 cycles, then start=1 for 1 cycle -> next cycle: state=1, led=8'h1B, seg=0; exactly 8 cycles later: state=2, led=0.
2. In ENTER, guess=6'h1B, commit rises -> state=3, seg=8'hFF, led=0, score=1, lives=3 for 4 cycles; then state=1, led=8'h37.
3. Round 2 with guess=6'h00 and commit rise -> seg=8'h80, led=8'h37, lives=2; after 4 cycles a new SHOW.
4. Miss three consecutive rounds -> after the third RESULT: state=4, seg=8'h80, led=score; a start rise then gives score=0, lives=3, state=1.
5. Commit:
   - commit pulsed during SHOW -> no effect.
   - commit held high from SHOW into ENTER -> state stays 2.
   - Drop commit, then raise it -> exactly one RESULT.
6. Reset asserted during ENTER with score=1, lives=2 -> next cycle all reset values; after start, led=8'h1B again.
